stream_unpacker: RTL
====================

STREAM_UNPACKER -- requirements
Module: stream_unpacker

Interface
REQ-001 Parameter X_SIZE, default 1280, pixels per line.
REQ-002 Parameter Y_SIZE, default 720, lines per frame.
REQ-003 in_stream_aclk  in  1  sole clock; all logic on rising edge.
REQ-004 periph_reset  in  1  synchronous, active-high reset.
REQ-005 in_stream_tdata  in  32  packed 24bpp pixel word; in_stream_tkeep  in  4  ignored.
REQ-006 in_stream_tvalid  in  1 / in_stream_tready  out  1  AXI-Stream handshake.
REQ-007 in_stream_tuser  in  1  start of frame, marks first word of frame; in_stream_tlast  in  1  end of line, marks last word of line.
REQ-008 pix_r, pix_g, pix_b  out  8 each  unpacked pixel.
REQ-009 pix_x  out  11, pix_y  out  10  coordinates of the presented pixel.
REQ-010 pix_sof  out  1  pixel (0,0); pix_eol  out  1  pixel x = X_SIZE-1.
REQ-011 pix_valid  out  1 / pix_ready  in  1  downstream handshake.
REQ-012 frame_done  out  1  one-cycle pulse when pixel (X_SIZE-1, Y_SIZE-1) transfers.
REQ-013 err_status  out  3  sticky flags: [0] short line, [1] long line, [2] unexpected SOF; err_clear  in  1  clears all flags.

Function
REQ-014 Pixel format: p = {r,g,b} = {p[23:16], p[15:8], p[7:0]}; three words carry four pixels. Word phase 0 yields p0 = w0[23:0] and saves w0[31:24]. Phase 1 yields p1 = {w1[15:0], saved8} and saves w1[31:16]. Phase 2 yields p2 = {w2[7:0], saved16} and then p3 = w2[31:8].
REQ-015 A line is X_SIZE*3/4 words (960 at default); X_SIZE is a multiple of 4.
REQ-016 State machine: WAIT_SOF, ACTIVE, DROP. WAIT_SOF discards words (tready=1) until a tuser word, which is processed as phase 0 at x=0, y=0, and the state becomes ACTIVE.
REQ-017 Word acceptance rule: tready = 1 in WAIT_SOF/DROP. In ACTIVE, tready = 1 only when the output register is empty or transferring this cycle, and no p3 is pending.
REQ-018 Latency: a word accepted in cycle N presents its first pixel with pix_valid = 1 in cycle N+1. For phase 2, p3 is presented in the cycle after p2 transfers.
REQ-019 Outputs hold stable while pix_valid = 1 and pix_ready = 0.
REQ-020 x increments on each pixel transfer. At x = X_SIZE-1, x wraps to 0 and y increments; at y = Y_SIZE-1, y wraps to 0 and the state returns to WAIT_SOF.
REQ-021 Correct tlast on word X_SIZE*3/4-1: phase resets to 0.
REQ-022 Early tlast (on an earlier word): set err[0]; emit that word's pixels; force phase 0, x = 0, y+1; remain ACTIVE.
REQ-023 Missing tlast on the expected last word: set err[1]; emit the word's pixels; enter DROP. DROP discards words through the next tlast, then sets phase 0, x = 0, y+1 and returns to ACTIVE.
REQ-024 tuser in ACTIVE/DROP at any position other than expected (0,0): set err[2]; realign to phase 0, x = 0, y = 0; enter ACTIVE. No pixels are emitted for the pending p3.
REQ-025 If tuser and tlast arrive on the same word, tuser handling applies first, then tlast handling.
REQ-026 If err_clear coincides with a new error event, the new error wins (flag reads 1).

Reset
REQ-027 While periph_reset = 1: state = WAIT_SOF, phase = 0, x = 0, y = 0, pix_valid = 0, in_stream_tready = 0, frame_done = 0, err_status = 0, pix_r/g/b = 0, pix_sof = 0, pix_eol = 0.
REQ-028 Reset mid-frame discards all partial words and pending pixels. The first cycle after reset has tready = 1 in WAIT_SOF.

Structure
REQ-029 Shared package video_pkg holds X_SIZE, Y_SIZE, WORDS_PER_LINE, the pixel byte-lane positions and the state encoding; the matching packer uses the same package.
REQ-030 Single module with no sub-modules; the phase counter and the 16-bit saved-byte register are local.

Verification
REQ-031 Three words 0x44332211, 0x88776655, 0xCCBBAA99 at phase 0 with pix_ready=1 -> pixels 0x332211, 0x665544, 0x998877, 0xCCBBAA at x = 0..3.
REQ-032 Full 1280x720 frame with random tvalid/pix_ready stalls -> 921600 pixels, a single frame_done, err_status = 0, pix_eol at every x = 1279.
REQ-033 Line 5 with tlast on word 500 -> err[0] = 1; next word yields x = 0, y = 6.
REQ-034 Line 2 with no tlast on word 959 and tlast on word 970 -> err[1] = 1; words 960-970 are dropped; next pixel is x = 0, y = 3.
REQ-035 tuser at y = 100 -> err[2] = 1; next pixel is (0,0) with pix_sof = 1. Then err_clear -> err_status = 0.
REQ-036 periph_reset asserted mid-line at x = 600 -> pix_valid = 0 next cycle; tready = 1 after release; non-tuser words are discarded until SOF.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions for the 24bpp stream unpacker and its matching packer.
// Holds the default frame geometry, the pixel byte-lane positions inside a
// 24-bit {r,g,b} pixel, the unpacker state encoding and a lane-split helper.
package video_pkg;

  localparam int unsigned X_SIZE         = 1280;
  localparam int unsigned Y_SIZE         = 720;
  localparam int unsigned WORDS_PER_LINE = X_SIZE * 3 / 4;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PIX_W  = 24;
  localparam int unsigned X_W    = 11;
  localparam int unsigned Y_W    = 10;

  // Byte lanes of a 24-bit pixel p = {r,g,b}
  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DROP     = 2'd2
  } unpack_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Split a 24-bit pixel into its colour lanes
  function automatic pixel_t split_pixel(input logic [PIX_W-1:0] p);
    pixel_t px;
    px.r = p[R_LSB +: 8];
    px.g = p[G_LSB +: 8];
    px.b = p[B_LSB +: 8];
    return px;
  endfunction

endpackage

// File: rtl/stream_unpacker.sv
// stream_unpacker: converts a 32-bit AXI-Stream carrying packed 24bpp pixels
// (three words hold four pixels) into one pixel per handshake with x/y
// coordinates, start-of-frame / end-of-line markers and sticky line/frame
// framing error flags.
//
// Ports
//   in_stream_aclk    clock, all logic on the rising edge
//   periph_reset      synchronous active-high reset
//   in_stream_tdata   packed pixel word (tkeep is ignored)
//   in_stream_tvalid / in_stream_tready   input handshake
//   in_stream_tuser   start of frame (first word)
//   in_stream_tlast   end of line (last word of a line)
//   pix_r/g/b, pix_x, pix_y, pix_sof, pix_eol   presented pixel
//   pix_valid / pix_ready                 output handshake
//   frame_done        pulse after the last pixel of a frame transfers
//   err_status        sticky {unexpected SOF, long line, short line}
//   err_clear         clears err_status
module stream_unpacker
  import video_pkg::*;
#(
  parameter int unsigned X_SIZE = video_pkg::X_SIZE,
  parameter int unsigned Y_SIZE = video_pkg::Y_SIZE
) (
  input  logic        in_stream_aclk,
  input  logic        periph_reset,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tlast,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done,
  output logic [2:0]  err_status,
  input  logic        err_clear
);

  localparam logic [10:0] X_LAST = 11'(X_SIZE - 1);
  localparam logic [10:0] X_PRE  = 11'(X_SIZE - 2);
  localparam logic [9:0]  Y_LAST = 10'(Y_SIZE - 1);

  unpack_state_t state;
  logic [1:0]    phase;
  logic [15:0]   saved;
  logic [10:0]   nx;          // x of the first pixel of the next word
  logic [9:0]    ny;
  logic          p3_pend;     // fourth pixel of a phase-2 word waiting for the output
  logic [23:0]   p3_pix;
  logic [10:0]   p3_x;
  logic [9:0]    p3_y;
  logic          eof_pend;    // frame ended, go idle once every pixel has left

  logic          out_free;
  logic          xfer;
  logic          accept;
  logic          proc;
  logic          sof_err;
  logic [1:0]    eff_phase;
  logic [10:0]   eff_x;
  logic [9:0]    eff_y;
  logic [23:0]   word_pix;
  logic [15:0]   saved_n;
  logic          last_word;
  logic          line_end;
  logic          early_last;
  logic          missing_last;
  logic [10:0]   x_adv;
  logic [10:0]   p3_xn;
  logic [9:0]    y_inc;
  pixel_t        word_px;
  pixel_t        p3_px;

  logic unused_keep;
  assign unused_keep = ^in_stream_tkeep;

  // Handshake, word decode and next-position arithmetic
  always_comb begin
    out_free = !pix_valid || pix_ready;
    xfer     = pix_valid && pix_ready;

    in_stream_tready = 1'b0;
    if (!periph_reset) begin
      if (state == ACTIVE) begin
        in_stream_tready = out_free && !p3_pend && !eof_pend;
      end else begin
        // A realigning SOF word needs the output register; plain words are discarded
        in_stream_tready = !(in_stream_tuser && !out_free);
      end
    end

    accept = in_stream_tvalid && in_stream_tready;
    proc   = accept && ((state == ACTIVE) || in_stream_tuser);

    sof_err = accept && in_stream_tuser && (state != WAIT_SOF) &&
              !((phase == 2'd0) && (nx == 11'd0) && (ny == 10'd0));

    // SOF realigns before the word is unpacked
    eff_phase = in_stream_tuser ? 2'd0  : phase;
    eff_x     = in_stream_tuser ? 11'd0 : nx;
    eff_y     = in_stream_tuser ? 10'd0 : ny;

    word_pix = in_stream_tdata[23:0];
    saved_n  = saved;
    case (eff_phase)
      2'd0: begin
        word_pix = in_stream_tdata[23:0];
        saved_n  = {saved[15:8], in_stream_tdata[31:24]};
      end
      2'd1: begin
        word_pix = {in_stream_tdata[15:0], saved[7:0]};
        saved_n  = in_stream_tdata[31:16];
      end
      default: begin
        word_pix = {in_stream_tdata[7:0], saved};
      end
    endcase

    last_word    = (eff_phase == 2'd2) && (eff_x == X_PRE);
    line_end     = in_stream_tlast || last_word;
    early_last   = in_stream_tlast && !last_word;
    missing_last = last_word && !in_stream_tlast;

    x_adv = (eff_phase == 2'd2) ? eff_x + 11'd2 : eff_x + 11'd1;
    p3_xn = eff_x + 11'd1;
    y_inc = (eff_y == Y_LAST) ? 10'd0 : eff_y + 10'd1;

    word_px = split_pixel(word_pix);
    p3_px   = split_pixel(p3_pix);
  end

  // State machine, position tracking and registered pixel output
  always_ff @(posedge in_stream_aclk) begin
    if (periph_reset) begin
      state      <= WAIT_SOF;
      phase      <= 2'd0;
      saved      <= 16'd0;
      nx         <= 11'd0;
      ny         <= 10'd0;
      p3_pend    <= 1'b0;
      p3_pix     <= 24'd0;
      p3_x       <= 11'd0;
      p3_y       <= 10'd0;
      eof_pend   <= 1'b0;
      pix_valid  <= 1'b0;
      pix_r      <= 8'd0;
      pix_g      <= 8'd0;
      pix_b      <= 8'd0;
      pix_x      <= 11'd0;
      pix_y      <= 10'd0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;
      err_status <= 3'd0;
    end else begin
      frame_done <= xfer && (pix_x == X_LAST) && (pix_y == Y_LAST);

      // A new error event outranks a coincident clear
      err_status <= (err_clear ? 3'd0 : err_status) |
                    {sof_err, proc && missing_last, proc && early_last};

      // Output register: a new word and a pending p3 never compete here
      if (proc) begin
        pix_valid <= 1'b1;
        pix_r     <= word_px.r;
        pix_g     <= word_px.g;
        pix_b     <= word_px.b;
        pix_x     <= eff_x;
        pix_y     <= eff_y;
        pix_sof   <= (eff_x == 11'd0) && (eff_y == 10'd0);
        pix_eol   <= (eff_x == X_LAST);
      end else if (p3_pend && out_free) begin
        pix_valid <= 1'b1;
        pix_r     <= p3_px.r;
        pix_g     <= p3_px.g;
        pix_b     <= p3_px.b;
        pix_x     <= p3_x;
        pix_y     <= p3_y;
        pix_sof   <= 1'b0;
        pix_eol   <= (p3_x == X_LAST);
      end else if (xfer) begin
        pix_valid <= 1'b0;
      end

      // Processing a word replaces (or drops) any pending p3
      if (proc) begin
        p3_pend <= (eff_phase == 2'd2);
        p3_pix  <= in_stream_tdata[31:8];
        p3_x    <= p3_xn;
        p3_y    <= eff_y;
      end else if (p3_pend && out_free) begin
        p3_pend <= 1'b0;
      end

      if (proc) begin
        saved    <= saved_n;
        phase    <= (line_end || (eff_phase == 2'd2)) ? 2'd0 : eff_phase + 2'd1;
        nx       <= line_end ? 11'd0 : x_adv;
        ny       <= line_end ? y_inc : eff_y;
        eof_pend <= line_end && (eff_y == Y_LAST);
        state    <= missing_last ? DROP : ACTIVE;
      end else if (accept && (state == DROP) && in_stream_tlast) begin
        // Position already advanced to the next line when DROP was entered
        state <= ACTIVE;
      end else if ((state == ACTIVE) && eof_pend && !p3_pend && out_free) begin
        state    <= WAIT_SOF;
        eof_pend <= 1'b0;
      end
    end
  end

endmodule
